// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and GF(2^8) helpers for the AES datapaths.
package aes_pkg;

  localparam int NB     = 4;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } dec_state_t;

  // Byte number (0 = bits [127:120]) of row r, column c in the column-major AES state.
  function automatic int byte_at(input int r, input int c);
    return NB * c + r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ acc;
      acc = xtime(acc);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine transform followed by the GF(2^8)
// multiplicative inverse, computed as x^254 through a square-and-multiply chain.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  localparam logic [7:0] AFF_C = 8'h05;

  logic [7:0] w_aff;
  logic [7:0] w_x2, w_x3, w_x6, w_x7, w_x14, w_x15, w_x30, w_x31;
  logic [7:0] w_x62, w_x63, w_x126, w_x127, w_x254;

  always_comb begin
    w_aff = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_aff[i] = i_in[(i + 2) % 8] ^ i_in[(i + 5) % 8] ^ i_in[(i + 7) % 8] ^ AFF_C[i];
    end
  end

  // Zero maps to zero through the power chain, matching the S-box convention.
  assign w_x2   = gmul(w_aff, w_aff);
  assign w_x3   = gmul(w_x2, w_aff);
  assign w_x6   = gmul(w_x3, w_x3);
  assign w_x7   = gmul(w_x6, w_aff);
  assign w_x14  = gmul(w_x7, w_x7);
  assign w_x15  = gmul(w_x14, w_aff);
  assign w_x30  = gmul(w_x15, w_x15);
  assign w_x31  = gmul(w_x30, w_aff);
  assign w_x62  = gmul(w_x31, w_x31);
  assign w_x63  = gmul(w_x62, w_aff);
  assign w_x126 = gmul(w_x63, w_x63);
  assign w_x127 = gmul(w_x126, w_aff);
  assign w_x254 = gmul(w_x127, w_x127);

  assign o_out = w_x254;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched via Key_Idx.
// Optional build macro AES_DEC_ABORT_EN adds an Abort input that cancels a running block.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR        = NR_128,
  parameter int KEY_IDX_W = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
`ifdef AES_DEC_ABORT_EN
  input  logic                 Abort,
`endif
  input  logic                 En_Dec,
  input  logic [127:0]         In_Dec,
  output logic [KEY_IDX_W-1:0] Key_Idx,
  input  logic [127:0]         Key_In,
  output logic                 Busy,
  output logic                 Ry_Dec,
  output logic [127:0]         Out_Dec
);

  dec_state_t r_fsm, w_fsmNext;

  logic [127:0]         r_state, w_stateNext;
  logic [127:0]         r_out, w_outNext;
  logic [KEY_IDX_W-1:0] r_keyIdx, w_keyIdxNext;
  logic                 r_busy, w_busyNext;
  logic                 r_ry, w_ryNext;
  logic                 w_start;

  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  // Row r of the state rotates right by r byte positions.
  for (genvar r = 0; r < NB; r++) begin : g_isr_row
    for (genvar c = 0; c < NB; c++) begin : g_isr_col
      localparam int DST = 127 - 8 * byte_at(r, c);
      localparam int SRC = 127 - 8 * byte_at(r, (c - r + NB) % NB);
      assign w_isr[DST -: 8] = r_state[SRC -: 8];
    end
  end

  for (genvar b = 0; b < 16; b++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .i_in  (w_isr[127 - 8 * b -: 8]),
      .o_out (w_isb[127 - 8 * b -: 8])
    );
  end

  assign w_ark = w_isb ^ Key_In;

  for (genvar c = 0; c < NB; c++) begin : g_imc
    localparam int B0 = 127 - 8 * byte_at(0, c);
    localparam int B1 = 127 - 8 * byte_at(1, c);
    localparam int B2 = 127 - 8 * byte_at(2, c);
    localparam int B3 = 127 - 8 * byte_at(3, c);
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_ark[B0 -: 8];
    assign w_a1 = w_ark[B1 -: 8];
    assign w_a2 = w_ark[B2 -: 8];
    assign w_a3 = w_ark[B3 -: 8];
    assign w_imc[B0 -: 8] = gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09);
    assign w_imc[B1 -: 8] = gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d);
    assign w_imc[B2 -: 8] = gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b);
    assign w_imc[B3 -: 8] = gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e);
  end

`ifdef AES_DEC_ABORT_EN
  assign w_start = En_Dec & ~Abort;
`else
  assign w_start = En_Dec;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_fsm    <= IDLE;
      r_state  <= '0;
      r_out    <= '0;
      r_keyIdx <= '0;
      r_busy   <= 1'b0;
      r_ry     <= 1'b0;
    end else begin
      r_fsm    <= w_fsmNext;
      r_state  <= w_stateNext;
      r_out    <= w_outNext;
      r_keyIdx <= w_keyIdxNext;
      r_busy   <= w_busyNext;
      r_ry     <= w_ryNext;
    end
  end

  // Round keys are consumed in reverse order, NR down to 0.
  always_comb begin
    w_fsmNext    = r_fsm;
    w_stateNext  = r_state;
    w_outNext    = r_out;
    w_keyIdxNext = r_keyIdx;
    w_busyNext   = r_busy;
    w_ryNext     = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (w_start) begin
          w_stateNext  = In_Dec;
          w_keyIdxNext = KEY_IDX_W'(NR);
          w_busyNext   = 1'b1;
          w_fsmNext    = INIT;
        end
      end
      INIT: begin
        w_stateNext  = r_state ^ Key_In;
        w_keyIdxNext = KEY_IDX_W'(NR - 1);
        w_fsmNext    = ROUND;
      end
      ROUND: begin
        w_stateNext = w_imc;
        if (r_keyIdx == KEY_IDX_W'(1)) begin
          w_keyIdxNext = '0;
          w_fsmNext    = FINAL;
        end else begin
          w_keyIdxNext = r_keyIdx - KEY_IDX_W'(1);
        end
      end
      FINAL: begin
        w_outNext    = w_ark;
        w_ryNext     = 1'b1;
        w_busyNext   = 1'b0;
        w_keyIdxNext = '0;
        w_fsmNext    = IDLE;
      end
      default: begin
        w_fsmNext = IDLE;
      end
    endcase
`ifdef AES_DEC_ABORT_EN
    if (Abort && r_busy) begin
      w_fsmNext    = IDLE;
      w_stateNext  = r_state;
      w_outNext    = r_out;
      w_keyIdxNext = '0;
      w_busyNext   = 1'b0;
      w_ryNext     = 1'b0;
    end
`endif
  end

  assign Key_Idx = r_keyIdx;
  assign Busy    = r_busy;
  assign Ry_Dec  = r_ry;
  assign Out_Dec = r_out;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors for NR=10 and NR=14 with a bench-side
// key schedule, key-index sequencing, handshake corner cases, async reset and (AES_DEC_ABORT_EN) abort.
module tb_aes_inv_cipher;

  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         en10 = 1'b0;
  logic         en14 = 1'b0;
  logic         abort10 = 1'b0;
  logic         abort14 = 1'b0;
  logic [127:0] inDec = '0;
  logic [3:0]   idx10, idx14;
  logic [127:0] key10, key14, out10, out14;
  logic         busy10, ry10, busy14, ry14;

  logic [127:0] rk10   [0:15];
  logic [127:0] rk14   [0:15];
  logic [127:0] rkTmp  [0:15];

  int checks   = 0;
  int failures = 0;

  assign key10 = rk10[idx10];
  assign key14 = rk14[idx14];

  always #5 Clk = ~Clk;

  aes_inv_cipher #(.NR(10), .KEY_IDX_W(4)) dut10 (
    .Clk     (Clk),
    .Rst     (Rst),
`ifdef AES_DEC_ABORT_EN
    .Abort   (abort10),
`endif
    .En_Dec  (en10),
    .In_Dec  (inDec),
    .Key_Idx (idx10),
    .Key_In  (key10),
    .Busy    (busy10),
    .Ry_Dec  (ry10),
    .Out_Dec (out10)
  );

  aes_inv_cipher #(.NR(14), .KEY_IDX_W(4)) dut14 (
    .Clk     (Clk),
    .Rst     (Rst),
`ifdef AES_DEC_ABORT_EN
    .Abort   (abort14),
`endif
    .En_Dec  (en14),
    .In_Dec  (inDec),
    .Key_Idx (idx14),
    .Key_In  (key14),
    .Busy    (busy14),
    .Ry_Dec  (ry14),
    .Out_Dec (out14)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] tbGmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (x^254) then the forward affine transform.
  function automatic logic [7:0] tbSbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    inv = x;
    for (int i = 0; i < 253; i++) inv = tbGmul(inv, x);
    for (int i = 0; i < 8; i++) begin
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] x);
    return {tbSbox(x[31:24]), tbSbox(x[23:16]), tbSbox(x[15:8]), tbSbox(x[7:0])};
  endfunction

  task automatic expandKey(input int nk, input logic [255:0] key, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int r = 0; r < 16; r++) rkTmp[r] = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rkTmp[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Starts one NR=10 block; returns at the falling edge right after the accept edge.
  task automatic applyStimulus(input logic [127:0] ct);
    inDec = ct;
    en10  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    en10 = 1'b0;
  endtask

  // Counts rising edges until Ry is seen; k = limit+1 means it never came.
  task automatic waitRy(input bit sel14, input int limit, output int k);
    k = 0;
    while (k < limit) begin
      @(posedge Clk);
      @(negedge Clk);
      k++;
      if (sel14 ? ry14 : ry10) return;
    end
    k = limit + 1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int busyCnt;
    int ryCnt;

    expandKey(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    for (int r = 0; r < 16; r++) rk10[r] = rkTmp[r];
    expandKey(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
    for (int r = 0; r < 16; r++) rk14[r] = rkTmp[r];

    #2 Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    checkOutput("rst_busy", 128'(busy10), 128'd0);
    checkOutput("rst_ry", 128'(ry10), 128'd0);
    checkOutput("rst_out", out10, 128'd0);
    checkOutput("rst_kidx", 128'(idx10), 128'd0);
    checkOutput("rst_out14", out14, 128'd0);
    checkOutput("rst_busy14", 128'(busy14), 128'd0);

    $display("[TB] AES-128 FIPS-197 C.1");
    applyStimulus(CT128);
    waitRy(1'b0, 20, k);
    checkOutput("lat10", 128'(k), 128'd11);
    checkOutput("pt10", out10, PT);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("ry10_drop", 128'(ry10), 128'd0);
    checkOutput("pt10_hold", out10, PT);

    $display("[TB] AES-256 FIPS-197 C.3");
    inDec = CT256;
    en14  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    en14 = 1'b0;
    waitRy(1'b1, 25, k);
    checkOutput("lat14", 128'(k), 128'd15);
    checkOutput("pt14", out14, PT);

    $display("[TB] Key_Idx sequence and Busy length");
    applyStimulus(CT128);
    busyCnt = 0;
    for (int j = 0; j <= 12; j++) begin
      checkOutput($sformatf("kidx%0d", j), 128'(idx10), (j <= 10) ? 128'(10 - j) : 128'd0);
      if (busy10) busyCnt++;
      if (j == 11) checkOutput("seq_ry", 128'(ry10), 128'd1);
      if (j < 12) begin
        @(posedge Clk);
        @(negedge Clk);
      end
    end
    checkOutput("busy_len", 128'(busyCnt), 128'd11);

    $display("[TB] En_Dec while busy is ignored");
    applyStimulus(CT128);
    ryCnt = 0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (ry10) ryCnt++;
      if (j == 5) en10 = 1'b1;
      if (j == 6) en10 = 1'b0;
    end
    checkOutput("busy_en_ry", 128'(ryCnt), 128'd1);
    checkOutput("busy_en_idle", 128'(busy10), 128'd0);

    $display("[TB] En_Dec held high re-triggers");
    inDec = CT128;
    en10  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    waitRy(1'b0, 20, k);
    checkOutput("hold_lat1", 128'(k), 128'd11);
    @(posedge Clk);
    @(negedge Clk);
    en10 = 1'b0;
    checkOutput("hold_busy2", 128'(busy10), 128'd1);
    checkOutput("hold_kidx2", 128'(idx10), 128'd10);
    waitRy(1'b0, 20, k);
    checkOutput("hold_lat2", 128'(k), 128'd11);
    checkOutput("hold_pt2", out10, PT);

    $display("[TB] async reset mid-run");
    applyStimulus(CT128);
    repeat (4) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    Rst = 1'b1;
    #1;
    checkOutput("arst_busy", 128'(busy10), 128'd0);
    checkOutput("arst_ry", 128'(ry10), 128'd0);
    checkOutput("arst_out", out10, 128'd0);
    checkOutput("arst_kidx", 128'(idx10), 128'd0);
    @(negedge Clk);
    Rst = 1'b0;
    ryCnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (ry10) ryCnt++;
    end
    checkOutput("arst_no_ry", 128'(ryCnt), 128'd0);

`ifdef AES_DEC_ABORT_EN
    $display("[TB] abort at FINAL");
    applyStimulus(CT128);
    waitRy(1'b0, 20, k);
    checkOutput("ab_pre_pt", out10, PT);
    applyStimulus(128'h0);
    repeat (10) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    abort10 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    abort10 = 1'b0;
    checkOutput("ab_ry", 128'(ry10), 128'd0);
    checkOutput("ab_busy", 128'(busy10), 128'd0);
    checkOutput("ab_kidx", 128'(idx10), 128'd0);
    checkOutput("ab_out", out10, PT);
    ryCnt = 0;
    for (int j = 0; j < 15; j++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (ry10) ryCnt++;
    end
    checkOutput("ab_no_ry", 128'(ryCnt), 128'd0);
    abort10 = 1'b1;
    en10    = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    abort10 = 1'b0;
    en10    = 1'b0;
    checkOutput("ab_idle_en", 128'(busy10), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
